bsg_cache_to_dram_ctrl_rx: RTL and testbench

Read-return path from the DRAM controller's read-data port (app_rd_data_*) back to the cache DMA engine. The controller's read data has no backpressure, so the block buffers returned beats in a small FIFO. It grants read-burst credits to the command side only when a whole burst is guaranteed to fit. It also checks burst framing and flags protocol errors.

---
 rtl/bsg_cache_to_dram_ctrl_rx_if.sv | 25 ++
 rtl/bsg_cache_to_dram_ctrl_rx.sv | 94 +++++++++
 tb/tb_bsg_cache_to_dram_ctrl_rx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_cache_to_dram_ctrl_rx_if.sv
// Handshake and data bundle between the DRAM read-data port, the command side and the DMA engine.
// The slave modport is the rx block; the master modport is whatever drives it.
interface bsg_cache_to_dram_ctrl_rx_if #(
  parameter int unsigned data_width_p = 16
);
  logic                    rd_burst_req_i;
  logic                    credit_avail_o;
  logic                    app_rd_data_valid_i;
  logic [data_width_p-1:0] app_rd_data_i;
  logic                    app_rd_data_end_i;
  logic [data_width_p-1:0] dma_data_o;
  logic                    dma_data_v_o;
  logic                    dma_data_yumi_i;
  logic [2:0]              err_o;

  modport slave (
    input  rd_burst_req_i, app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i, dma_data_yumi_i,
    output credit_avail_o, dma_data_o, dma_data_v_o, err_o
  );

  modport master (
    output rd_burst_req_i, app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i, dma_data_yumi_i,
    input  credit_avail_o, dma_data_o, dma_data_v_o, err_o
  );
endinterface

// File: rtl/bsg_cache_to_dram_ctrl_rx.sv
// DRAM read-return buffer: first-word fall-through FIFO with burst-credit reservation and
// sticky framing/overflow error flags.
module bsg_cache_to_dram_ctrl_rx #(
  parameter int unsigned dma_data_width_p      = 16,
  parameter int unsigned dram_ctrl_burst_len_p = 4,
  parameter int unsigned fifo_els_p            = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  bsg_cache_to_dram_ctrl_rx_if.slave   rx_if
);

  localparam int unsigned ptr_w_lp  = $clog2(fifo_els_p);
  localparam int unsigned cnt_w_lp  = ptr_w_lp + 1;
  localparam int unsigned sum_w_lp  = cnt_w_lp + 1;
  localparam int unsigned beat_w_lp = $clog2(dram_ctrl_burst_len_p);

  localparam logic [cnt_w_lp-1:0]  els_lp       = cnt_w_lp'(fifo_els_p);
  localparam logic [cnt_w_lp-1:0]  burst_lp     = cnt_w_lp'(dram_ctrl_burst_len_p);
  localparam logic [beat_w_lp-1:0] last_beat_lp = beat_w_lp'(dram_ctrl_burst_len_p - 1);

  logic [dma_data_width_p-1:0] mem_q [fifo_els_p];

  logic [ptr_w_lp-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0]  rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]  occ_q, occ_d;
  logic [cnt_w_lp-1:0]  res_q, res_d;
  logic [beat_w_lp-1:0] beat_cnt_q, beat_cnt_d;
  logic [2:0]           err_q, err_d;

  logic enq, deq, grant, credit_c, last_beat_c;
  logic [sum_w_lp-1:0] committed_c;

  // A full burst fits only if everything already buffered or promised leaves room for it.
  assign committed_c = sum_w_lp'(occ_q) + sum_w_lp'(res_q) + sum_w_lp'(burst_lp);
  assign credit_c    = (committed_c <= sum_w_lp'(els_lp));
  assign last_beat_c = (beat_cnt_q == last_beat_lp);

  assign deq   = rx_if.dma_data_yumi_i && (occ_q != '0);
  assign enq   = rx_if.app_rd_data_valid_i && ((occ_q != els_lp) || deq);
  assign grant = rx_if.rd_burst_req_i && credit_c;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    res_d      = res_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;

    if (enq) wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
    if (deq) rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);

    occ_d = occ_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    res_d = res_q + (grant ? burst_lp : '0) - cnt_w_lp'(enq && (res_q != '0));

    // Beat counter free-runs on every valid beat; end_i is only checked, never used to realign.
    if (rx_if.app_rd_data_valid_i) begin
      beat_cnt_d = beat_cnt_q + beat_w_lp'(1);
      if (!enq)                                  err_d[0] = 1'b1;
      if (res_q == '0)                           err_d[1] = 1'b1;
      if (rx_if.app_rd_data_end_i != last_beat_c) err_d[2] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      res_q      <= '0;
      beat_cnt_q <= '0;
      err_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      res_q      <= res_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  // Data storage carries no reset; validity is tracked by occupancy alone.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= rx_if.app_rd_data_i;
  end

  assign rx_if.credit_avail_o = credit_c;
  assign rx_if.dma_data_v_o   = (occ_q != '0);
  assign rx_if.dma_data_o     = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign rx_if.err_o          = err_q;

endmodule

// File: tb/tb_bsg_cache_to_dram_ctrl_rx.sv
// Scenario bench for the DRAM read-return buffer: expected beats are queued as they are
// driven and compared in order as the DMA side consumes them.
module tb_bsg_cache_to_dram_ctrl_rx;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [15:0] sb [$];

  bsg_cache_to_dram_ctrl_rx_if #(.data_width_p(16)) bus ();

  bsg_cache_to_dram_ctrl_rx #(
    .dma_data_width_p      (16),
    .dram_ctrl_burst_len_p (4),
    .fifo_els_p            (8)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .rx_if   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Apply inputs at a falling edge, step through one rising edge, return at the next falling edge.
  task automatic drive(input logic req, input logic v, input logic [15:0] d,
                       input logic e, input logic y);
    bus.rd_burst_req_i      = req;
    bus.app_rd_data_valid_i = v;
    bus.app_rd_data_i       = d;
    bus.app_rd_data_end_i   = e;
    bus.dma_data_yumi_i     = y;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.rd_burst_req_i = 1'b0; bus.app_rd_data_valid_i = 1'b0; bus.app_rd_data_i = '0;
    bus.app_rd_data_end_i = 1'b0; bus.dma_data_yumi_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus.dma_data_v_o !== 1'b0) begin errors++; $display("FAIL reset_v: got %b want 0", bus.dma_data_v_o); end
    checks++; if (bus.dma_data_o !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", bus.dma_data_o); end
    checks++; if (bus.credit_avail_o !== 1'b1) begin errors++; $display("FAIL reset_credit: got %b want 1", bus.credit_avail_o); end
    checks++; if (bus.err_o !== 3'b000) begin errors++; $display("FAIL reset_err: got %b want 000", bus.err_o); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_one_burst();
    logic [15:0] d;
    do_reset();
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    checks++; if (bus.credit_avail_o !== 1'b1) begin errors++; $display("FAIL burst_credit_req: got %b want 1", bus.credit_avail_o); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        checks++;
        if (bus.dma_data_v_o !== 1'b1 || sb.size() == 0 || bus.dma_data_o !== sb[0]) begin
          errors++; $display("FAIL burst_data%0d: got v=%b d=%h want %h", i, bus.dma_data_v_o, bus.dma_data_o, (sb.size() > 0) ? sb[0] : 16'hxxxx);
        end
        if (sb.size() > 0) void'(sb.pop_front());
      end
      d = 16'h1111 * 16'(i + 1);
      if (i < 4) begin
        sb.push_back(d);
        drive(1'b0, 1'b1, d, (i == 3), 1'b1);
        checks++; if (bus.credit_avail_o !== 1'b1) begin errors++; $display("FAIL burst_credit%0d: got %b want 1", i, bus.credit_avail_o); end
      end else begin
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      end
    end
    checks++; if (bus.dma_data_v_o !== 1'b0) begin errors++; $display("FAIL burst_drained: got v=%b want 0", bus.dma_data_v_o); end
    checks++; if (bus.err_o !== 3'b000) begin errors++; $display("FAIL burst_err: got %b want 000", bus.err_o); end
  endtask

  task automatic test_credit();
    logic [15:0] d;
    do_reset();
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.credit_avail_o !== 1'b1) begin errors++; $display("FAIL credit_after1: got %b want 1", bus.credit_avail_o); end
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.credit_avail_o !== 1'b0) begin errors++; $display("FAIL credit_after2: got %b want 0", bus.credit_avail_o); end
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.credit_avail_o !== 1'b0) begin errors++; $display("FAIL credit_after3: got %b want 0", bus.credit_avail_o); end
    for (int i = 0; i < 8; i++) begin
      d = 16'hB000 + 16'(i);
      sb.push_back(d);
      drive(1'b0, 1'b1, d, (i % 4 == 3), 1'b0);
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.credit_avail_o !== 1'b0) begin errors++; $display("FAIL credit_full: got %b want 0", bus.credit_avail_o); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus.dma_data_v_o !== 1'b1 || sb.size() == 0 || bus.dma_data_o !== sb[0]) begin
        errors++; $display("FAIL credit_data%0d: got v=%b d=%h want %h", k, bus.dma_data_v_o, bus.dma_data_o, (sb.size() > 0) ? sb[0] : 16'hxxxx);
      end
      if (sb.size() > 0) void'(sb.pop_front());
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      if (k == 2) begin
        checks++; if (bus.credit_avail_o !== 1'b0) begin errors++; $display("FAIL credit_3yumi: got %b want 0", bus.credit_avail_o); end
      end
      if (k == 3) begin
        checks++; if (bus.credit_avail_o !== 1'b1) begin errors++; $display("FAIL credit_4yumi: got %b want 1", bus.credit_avail_o); end
      end
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.dma_data_v_o !== 1'b0) begin errors++; $display("FAIL credit_drained: got v=%b want 0", bus.dma_data_v_o); end
    checks++; if (bus.err_o !== 3'b000) begin errors++; $display("FAIL credit_err: got %b want 000", bus.err_o); end
  endtask

  task automatic test_framing();
    logic [15:0] d;
    do_reset();
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      d = 16'hF000 + 16'(i);
      sb.push_back(d);
      drive(1'b0, 1'b1, d, (i == 2), 1'b0);
      if (i == 1) begin
        checks++; if (bus.err_o !== 3'b000) begin errors++; $display("FAIL frame_before: got %b want 000", bus.err_o); end
      end
      if (i == 2) begin
        checks++; if (bus.err_o !== 3'b100) begin errors++; $display("FAIL frame_err: got %b want 100", bus.err_o); end
      end
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.dma_data_v_o !== 1'b1 || sb.size() == 0 || bus.dma_data_o !== sb[0]) begin
        errors++; $display("FAIL frame_data%0d: got v=%b d=%h want %h", k, bus.dma_data_v_o, bus.dma_data_o, (sb.size() > 0) ? sb[0] : 16'hxxxx);
      end
      if (sb.size() > 0) void'(sb.pop_front());
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.dma_data_v_o !== 1'b0) begin errors++; $display("FAIL frame_drained: got v=%b want 0", bus.dma_data_v_o); end
  endtask

  task automatic test_unreq_overflow();
    logic [15:0] d;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      d = 16'hA000 + 16'(i);
      if (i < 8) sb.push_back(d);
      drive(1'b0, 1'b1, d, (i % 4 == 3), 1'b0);
      if (i == 0) begin
        checks++; if (bus.err_o !== 3'b010) begin errors++; $display("FAIL unreq_err: got %b want 010", bus.err_o); end
      end
      if (i == 7) begin
        checks++; if (bus.err_o !== 3'b010) begin errors++; $display("FAIL fill8_err: got %b want 010", bus.err_o); end
      end
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.err_o !== 3'b011) begin errors++; $display("FAIL overflow_err: got %b want 011", bus.err_o); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus.dma_data_v_o !== 1'b1 || sb.size() == 0 || bus.dma_data_o !== sb[0]) begin
        errors++; $display("FAIL ovf_data%0d: got v=%b d=%h want %h", k, bus.dma_data_v_o, bus.dma_data_o, (sb.size() > 0) ? sb[0] : 16'hxxxx);
      end
      if (sb.size() > 0) void'(sb.pop_front());
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.dma_data_v_o !== 1'b0) begin errors++; $display("FAIL ovf_drained: got v=%b d=%h want v=0", bus.dma_data_v_o, bus.dma_data_o); end
  endtask

  task automatic test_full_simul();
    logic [15:0] d;
    do_reset();
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      d = 16'hD000 + 16'(i);
      sb.push_back(d);
      drive(1'b0, 1'b1, d, (i % 4 == 3), 1'b0);
    end
    checks++;
    if (bus.dma_data_v_o !== 1'b1 || sb.size() == 0 || bus.dma_data_o !== sb[0]) begin
      errors++; $display("FAIL simul_head: got v=%b d=%h want %h", bus.dma_data_v_o, bus.dma_data_o, (sb.size() > 0) ? sb[0] : 16'hxxxx);
    end
    if (sb.size() > 0) void'(sb.pop_front());
    sb.push_back(16'hD008);
    drive(1'b0, 1'b1, 16'hD008, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.err_o !== 3'b010) begin errors++; $display("FAIL simul_err: got %b want 010", bus.err_o); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus.dma_data_v_o !== 1'b1 || sb.size() == 0 || bus.dma_data_o !== sb[0]) begin
        errors++; $display("FAIL simul_data%0d: got v=%b d=%h want %h", k, bus.dma_data_v_o, bus.dma_data_o, (sb.size() > 0) ? sb[0] : 16'hxxxx);
      end
      if (sb.size() > 0) void'(sb.pop_front());
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.dma_data_v_o !== 1'b0) begin errors++; $display("FAIL simul_drained: got v=%b want 0", bus.dma_data_v_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'hC000, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'hC001, 1'b0, 1'b0);
    bus.app_rd_data_valid_i = 1'b0;
    checks++; if (bus.dma_data_v_o !== 1'b1) begin errors++; $display("FAIL arst_pre_v: got %b want 1", bus.dma_data_v_o); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.dma_data_v_o !== 1'b0) begin errors++; $display("FAIL arst_v: got %b want 0", bus.dma_data_v_o); end
    checks++; if (bus.dma_data_o !== 16'h0) begin errors++; $display("FAIL arst_data: got %h want 0000", bus.dma_data_o); end
    checks++; if (bus.credit_avail_o !== 1'b1) begin errors++; $display("FAIL arst_credit: got %b want 1", bus.credit_avail_o); end
    checks++; if (bus.err_o !== 3'b000) begin errors++; $display("FAIL arst_err: got %b want 000", bus.err_o); end
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    sb.push_back(16'hC002);
    drive(1'b0, 1'b1, 16'hC002, 1'b0, 1'b0);
    checks++; if (bus.err_o !== 3'b010) begin errors++; $display("FAIL arst_unreq: got %b want 010", bus.err_o); end
    checks++;
    if (bus.dma_data_v_o !== 1'b1 || sb.size() == 0 || bus.dma_data_o !== sb[0]) begin
      errors++; $display("FAIL arst_data_after: got v=%b d=%h want %h", bus.dma_data_v_o, bus.dma_data_o, (sb.size() > 0) ? sb[0] : 16'hxxxx);
    end
    if (sb.size() > 0) void'(sb.pop_front());
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.dma_data_v_o !== 1'b0) begin errors++; $display("FAIL arst_drained: got v=%b want 0", bus.dma_data_v_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.rd_burst_req_i = 1'b0; bus.app_rd_data_valid_i = 1'b0; bus.app_rd_data_i = '0;
    bus.app_rd_data_end_i = 1'b0; bus.dma_data_yumi_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_one_burst();
    test_credit();
    test_framing();
    test_unreq_overflow();
    test_full_simul();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
